inject_ctrl: RTL

Local-port injection scheduler for the bufferless age-priority router. It buffers flits from the attached resource in a small FIFO and stamps each with a saturating age. It presents the oldest flit to arbitration slot 4 only in cycles when at least one network input is empty, so a free output is guaranteed. It tracks starvation of the head flit and raises a throttle request once a limit is exceeded.

---
 rtl/inject_ctrl_if.sv | 43 ++++
 rtl/inject_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inject_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : inject_ctrl_if
//  Description : Bundle of the resource-side push port and the router-side
//                injection port of the local-port injection scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inject_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AGE_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Resource side
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    // Router side
    logic [3:0]        net_valid;
    logic              inj_valid;
    logic [DATA_W-1:0] inj_data;
    logic [AGE_W-1:0]  inj_age;
    logic              inj_ack;

    // Status
    logic              starve;
    logic [CNT_W-1:0]  count;

    // Environment view: resource plus router
    modport master (
        output res_valid, res_data, net_valid, inj_ack,
        input  res_ready, inj_valid, inj_data, inj_age, starve, count
    );

    // Scheduler view
    modport slave (
        input  res_valid, res_data, net_valid, inj_ack,
        output res_ready, inj_valid, inj_data, inj_age, starve, count
    );
endinterface
`default_nettype wire

// File: rtl/inject_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inject_ctrl
//  Description : Injection scheduler for the bufferless age-priority router.
//                Buffers resource flits in a FIFO, ages them, offers the head
//                to arbitration slot 4 only when a network input is empty,
//                and flags starvation of the head flit.
//  Revision    : 1.0 - initial release
// ============================================================================
module inject_ctrl #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int AGE_W        = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    inject_ctrl_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
    localparam logic [15:0]      c_LIMIT   = 16'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] c_AGE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STARVED = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [AGE_W-1:0]  r_age  [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    state_t            r_state;
    logic [15:0]       r_bcnt;
    logic              r_starve;

    logic              w_empty;
    logic              w_full;
    logic              w_inj_valid;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [DEPTH-1:0]  w_occ;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    // A free output exists only when at least one network input is idle
    assign w_inj_valid = !w_empty && !(&bus.net_valid);
    assign w_push      = bus.res_valid && !w_full;
    assign w_pop       = w_inj_valid && bus.inj_ack;

    assign bus.res_ready = !w_full;
    assign bus.inj_valid = w_inj_valid;
    assign bus.inj_data  = w_empty ? '0 : r_data[r_rd_ptr];
    assign bus.inj_age   = w_empty ? '0 : r_age[r_rd_ptr];
    assign bus.starve    = r_starve;
    assign bus.count     = r_count;

    // Occupancy after this edge, used by the head state machine
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Slot i is occupied when its distance from the head is below count
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Payload storage; contents are only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) r_data[r_wr_ptr] <= bus.res_data;
    end

    // Per-entry saturating age; a fresh push restarts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_age[i] <= '0;
                end else if (w_occ[i] && !(w_pop && (r_rd_ptr == PTR_W'(i)))
                             && (r_age[i] != c_AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // Head-flit starvation tracker with registered starve flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bcnt   <= '0;
            r_starve <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // First cycle of a new head is not counted as blocked
                    r_bcnt   <= '0;
                    r_starve <= 1'b0;
                    if (!w_empty && (w_count_next != '0)) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_pop) begin
                        r_bcnt  <= '0;
                        r_state <= (w_count_next == '0) ? ST_IDLE : ST_WAIT;
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                        if ((r_bcnt + 16'd1) == c_LIMIT) begin
                            r_state  <= ST_STARVED;
                            r_starve <= 1'b1;
                        end
                    end
                end
                ST_STARVED: begin
                    // Counter holds at the limit until the head leaves
                    if (w_pop) begin
                        r_bcnt   <= '0;
                        r_starve <= 1'b0;
                        r_state  <= (w_count_next == '0) ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_bcnt   <= '0;
                    r_starve <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
